// File: rtl/avl_arb_pkg.sv
// Shared types and helpers for the Avalon-ST packet arbiters.
// Holds the FSM state type, the statistics width and the round-robin pick function.
package avl_arb_pkg;

  localparam int STAT_W = 32;
  localparam int RR_MAX = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Scans downward so the last hit wins, which is the closest request at or after ptr.
  // Requests above the real input count are zero, so a fixed 16-wide wrap is equivalent.
  function automatic logic [4:0] rr_pick(input logic [RR_MAX-1:0] req, input logic [3:0] ptr);
    logic [4:0] pick;
    logic [3:0] k;
    pick = '0;
    for (int i = RR_MAX - 1; i >= 0; i--) begin
      k = ptr + 4'(i);
      if (req[k]) pick = {1'b1, k};
    end
    return pick;
  endfunction

endpackage

// File: rtl/avl_stream_pkt_arb_if.sv
// Bundle of the merged Avalon-ST buses: NUM_IN sources in, one sink out, plus hints.
// slave is the arbiter view, master is the environment driving sources and sink.
interface avl_stream_pkt_arb_if #(
  parameter int NUM_IN  = 4,
  parameter int WIDTH   = 512,
  parameter int EMPTY_W = $clog2(WIDTH / 8),
  parameter int CHAN_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);
  logic [NUM_IN*WIDTH-1:0]   in_data;
  logic [NUM_IN-1:0]         in_valid;
  logic [NUM_IN-1:0]         in_ready;
  logic [NUM_IN-1:0]         in_sop;
  logic [NUM_IN-1:0]         in_eop;
  logic [NUM_IN*EMPTY_W-1:0] in_empty;
  logic [NUM_IN-1:0]         in_almost_full;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_sop;
  logic                      out_eop;
  logic [EMPTY_W-1:0]        out_empty;
  logic [CHAN_W-1:0]         out_channel;
  logic                      out_almost_full;
  logic                      drop_pulse;

  modport slave (
    input  in_data, in_valid, in_sop, in_eop, in_empty, out_ready, out_almost_full,
    output in_ready, in_almost_full, out_data, out_valid, out_sop, out_eop,
           out_empty, out_channel, drop_pulse
  );

  modport master (
    output in_data, in_valid, in_sop, in_eop, in_empty, out_ready, out_almost_full,
    input  in_ready, in_almost_full, out_data, out_valid, out_sop, out_eop,
           out_empty, out_channel, drop_pulse
  );
endinterface

// File: rtl/avl_rr_sel.sv
// Combinational round-robin selector: first asserted request at or after ptr_i, wrapping.
// Supports up to 16 requesters.
module avl_rr_sel
  import avl_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);
  logic [4:0] pick;

  always_comb begin
    pick    = rr_pick(RR_MAX'(req_i), 4'(ptr_i));
    found_o = pick[4];
    idx_o   = IDX_W'(pick[3:0]);
  end
endmodule

// File: rtl/avl_stream_pkt_arb.sv
// Packet-level round-robin merge of NUM_IN Avalon-ST sources; grant held sop..eop.
// Define AVL_STREAM_PKT_ARB_STATS_EN to add per-input packet and orphan-drop counters.
module avl_stream_pkt_arb
  import avl_arb_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int WIDTH   = 512,
  parameter int EMPTY_W = $clog2(WIDTH / 8),
  parameter int CHAN_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input logic clk,
  input logic rst_n,
  avl_stream_pkt_arb_if.slave bus
`ifdef AVL_STREAM_PKT_ARB_STATS_EN
  ,
  output logic [NUM_IN*STAT_W-1:0] pkt_cnt,
  output logic [STAT_W-1:0]        drop_cnt
`endif
);
  arb_state_t          state_q, state_d;
  logic [CHAN_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CHAN_W-1:0]   grant_q, grant_d;
  logic                out_valid_q, out_valid_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;
  logic [EMPTY_W-1:0]  out_empty_q, out_empty_d;
  logic [CHAN_W-1:0]   out_channel_q, out_channel_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [NUM_IN-1:0]   in_af_q;

  logic [WIDTH-1:0]    in_data_a  [NUM_IN];
  logic [EMPTY_W-1:0]  in_empty_a [NUM_IN];
  logic [NUM_IN-1:0]   cand, orphan, in_ready;
  logic                sel_found, en, accept, drop_pulse;
  logic [CHAN_W-1:0]   sel_idx;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign in_data_a[gi]  = bus.in_data[gi*WIDTH +: WIDTH];
      assign in_empty_a[gi] = bus.in_empty[gi*EMPTY_W +: EMPTY_W];
    end
  endgenerate

  assign cand = bus.in_valid & bus.in_sop;

  avl_rr_sel #(.N(NUM_IN), .IDX_W(CHAN_W)) u_sel (
    .req_i  (cand),
    .ptr_i  (rr_ptr_q),
    .found_o(sel_found),
    .idx_o  (sel_idx)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    out_valid_d   = out_valid_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_empty_d   = out_empty_q;
    out_channel_d = out_channel_q;
    out_data_d    = out_data_q;
    in_ready      = '0;
    orphan        = '0;
    accept        = 1'b0;
    en            = ~out_valid_q | bus.out_ready;

    case (state_q)
      IDLE: begin
        // Beats without sop arriving between packets can never be framed; swallow them.
        orphan   = rst_n ? (bus.in_valid & ~bus.in_sop) : '0;
        in_ready = orphan;
        if (!bus.out_almost_full && sel_found) begin
          grant_d = sel_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        in_ready[grant_q] = en & rst_n;
        accept = en & bus.in_valid[grant_q];
        if (accept && bus.in_eop[grant_q]) begin
          rr_ptr_d = (grant_q == CHAN_W'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_valid_d   = 1'b1;
      out_sop_d     = bus.in_sop[grant_q];
      out_eop_d     = bus.in_eop[grant_q];
      out_empty_d   = in_empty_a[grant_q];
      out_channel_d = grant_q;
      out_data_d    = in_data_a[grant_q];
    end else if (en) begin
      out_valid_d = 1'b0;
    end
    drop_pulse = |orphan;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_empty_q   <= '0;
      out_channel_q <= '0;
      out_data_q    <= '0;
      in_af_q       <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      out_valid_q   <= out_valid_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_empty_q   <= out_empty_d;
      out_channel_q <= out_channel_d;
      out_data_q    <= out_data_d;
      in_af_q       <= {NUM_IN{bus.out_almost_full}};
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.in_almost_full = in_af_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_sop        = out_sop_q;
  assign bus.out_eop        = out_eop_q;
  assign bus.out_empty      = out_empty_q;
  assign bus.out_channel    = out_channel_q;
  assign bus.out_data       = out_data_q;
  assign bus.drop_pulse     = drop_pulse;

`ifdef AVL_STREAM_PKT_ARB_STATS_EN
  logic [STAT_W-1:0] pkt_cnt_q [NUM_IN];
  logic [STAT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++) pkt_cnt_q[i] <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (accept && bus.in_eop[grant_q]) pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 1'b1;
      drop_cnt_q <= drop_cnt_q + STAT_W'($countones(orphan));
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_stats
      assign pkt_cnt[gi*STAT_W +: STAT_W] = pkt_cnt_q[gi];
    end
  endgenerate
  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_avl_stream_pkt_arb.sv
// Directed bench for avl_stream_pkt_arb: latency, fairness, backpressure, almost-full,
// orphan drop and mid-packet reset, with hand-computed expectations.
module tb_avl_stream_pkt_arb;
  localparam int NI = 4;
  localparam int W  = 64;
  localparam int EW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  avl_stream_pkt_arb_if #(.NUM_IN(NI), .WIDTH(W)) bus ();

`ifdef AVL_STREAM_PKT_ARB_STATS_EN
  logic [NI*32-1:0] pkt_cnt;
  logic [31:0]      drop_cnt;
`endif

  avl_stream_pkt_arb #(.NUM_IN(NI), .WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef AVL_STREAM_PKT_ARB_STATS_EN
    ,
    .pkt_cnt (pkt_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic s, input logic e,
                       input logic [EW-1:0] emp, input logic [W-1:0] d);
    bus.in_valid[i]           = v;
    bus.in_sop[i]             = s;
    bus.in_eop[i]             = e;
    bus.in_empty[i*EW +: EW]  = emp;
    bus.in_data[i*W +: W]     = d;
  endtask

  task automatic idle_all();
    bus.in_valid = '0;
    bus.in_sop   = '0;
    bus.in_eop   = '0;
    bus.in_empty = '0;
    bus.in_data  = '0;
  endtask

  logic [1:0] fexp [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic       pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int  n, k, m;
    logic prev, rdy;

    // ---- reset, with an orphan presented while reset is held
    rst_n = 1'b0;
    idle_all();
    bus.out_ready       = 1'b1;
    bus.out_almost_full = 1'b0;
    drive(1, 1'b1, 1'b0, 1'b0, 3'd0, 64'h55);
    repeat (3) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_channel", bus.out_channel, 0);
    chk("rst_out_sop_eop", {bus.out_sop, bus.out_eop}, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_drop_pulse", bus.drop_pulse, 0);
    chk("rst_in_af", bus.in_almost_full, 0);
    idle_all();
    rst_n = 1'b1;
    tick();

    // ---- single source, 3-beat packet, 2-cycle first latency
    drive(0, 1'b1, 1'b1, 1'b0, 3'd0, 64'hA0);
    #1 chk("t1_idle_ready", bus.in_ready, 0);
    tick();
    chk("t1_grant_no_out", bus.out_valid, 0);
    chk("t1_busy_ready", bus.in_ready, 4'b0001);
    tick();
    chk("t1_b0_valid", bus.out_valid, 1);
    chk("t1_b0_data", bus.out_data, 64'hA0);
    chk("t1_b0_sop_eop", {bus.out_sop, bus.out_eop}, 2'b10);
    chk("t1_b0_chan", bus.out_channel, 0);
    drive(0, 1'b1, 1'b0, 1'b0, 3'd0, 64'hA1);
    tick();
    chk("t1_b1_data", bus.out_data, 64'hA1);
    chk("t1_b1_sop_eop", {bus.out_sop, bus.out_eop}, 2'b00);
    drive(0, 1'b1, 1'b0, 1'b1, 3'd5, 64'hA2);
    tick();
    chk("t1_b2_data", bus.out_data, 64'hA2);
    chk("t1_b2_eop", bus.out_eop, 1);
    chk("t1_b2_empty", bus.out_empty, 5);
    drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    tick();
    chk("t1_done", bus.out_valid, 0);

    // ---- fairness: all four sources offer single-beat packets continuously
    for (int i = 0; i < NI; i++) drive(i, 1'b1, 1'b1, 1'b1, 3'd0, 64'h100 + 64'(i));
    n = 0;
    prev = 1'b0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      tick();
      if (bus.out_valid) begin
        $display("fair pkt %0d: channel=%0d data=%0h", n, bus.out_channel, bus.out_data);
        chk("fair_chan", bus.out_channel, fexp[n]);
        chk("fair_data", bus.out_data, 64'h100 + 64'(fexp[n]));
        if (n > 0) chk("fair_gap", prev, 0);
        n++;
      end
      prev = bus.out_valid;
    end
    chk("fair_count", n, 8);
    idle_all();
    tick();
    chk("fair_idle", bus.out_valid, 0);

    // ---- backpressure: 8-beat packet on in2, out_ready pattern 1,0,0,1
    k = 0;
    m = 0;
    for (int c = 0; c < 80 && m < 8; c++) begin
      bus.out_ready = pat[c % 4];
      if (k < 8) drive(2, 1'b1, k == 0, k == 7, 3'd0, 64'h200 + 64'(k));
      else       drive(2, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
      #1;
      rdy = bus.in_ready[2];
      if (bus.out_valid) begin
        chk("bp_data", bus.out_data, 64'h200 + 64'(m));
        chk("bp_sop_eop", {bus.out_sop, bus.out_eop}, {m == 0, m == 7});
        chk("bp_chan", bus.out_channel, 2);
        if (bus.out_ready) begin
          $display("bp beat %0d: data=%0h", m, bus.out_data);
          m++;
        end
      end
      @(posedge clk);
      #1;
      if (rdy && k < 8) k++;
    end
    chk("bp_rx_count", m, 8);
    chk("bp_tx_count", k, 8);
    bus.out_ready = 1'b1;
    idle_all();
    tick();
    chk("bp_idle", bus.out_valid, 0);

    // ---- almost-full blocks the start of a packet, not its continuation
    bus.out_almost_full = 1'b1;
    drive(2, 1'b1, 1'b1, 1'b0, 3'd0, 64'h300);
    #1 chk("af_hint_delay", bus.in_almost_full, 0);
    tick();
    chk("af_hint", bus.in_almost_full, 4'hF);
    chk("af_hold_ready", bus.in_ready, 0);
    tick();
    tick();
    chk("af_hold_ready2", bus.in_ready, 0);
    chk("af_hold_valid", bus.out_valid, 0);
    bus.out_almost_full = 1'b0;
    tick();
    chk("af_grant", bus.in_ready, 4'b0100);
    bus.out_almost_full = 1'b1;
    #1 chk("af_mid_ready", bus.in_ready, 4'b0100);
    tick();
    chk("af_b0_data", bus.out_data, 64'h300);
    chk("af_b0_chan", bus.out_channel, 2);
    drive(2, 1'b1, 1'b0, 1'b1, 3'd2, 64'h301);
    #1 chk("af_b1_ready", bus.in_ready, 4'b0100);
    tick();
    chk("af_b1_data", bus.out_data, 64'h301);
    chk("af_b1_eop_empty", {bus.out_eop, bus.out_empty}, {1'b1, 3'd2});
    idle_all();
    bus.out_almost_full = 1'b0;
    tick();
    chk("af_idle", bus.out_valid, 0);
    tick();

    // ---- orphan beats in IDLE
    drive(1, 1'b1, 1'b0, 1'b0, 3'd0, 64'h400);
    #1 chk("orph_ready", bus.in_ready, 4'b0010);
    chk("orph_pulse", bus.drop_pulse, 1);
    tick();
    idle_all();
    #1 chk("orph_pulse_end", bus.drop_pulse, 0);
    chk("orph_no_out", bus.out_valid, 0);
`ifdef AVL_STREAM_PKT_ARB_STATS_EN
    chk("orph_drop_cnt", drop_cnt, 1);
`endif
    drive(0, 1'b1, 1'b0, 1'b0, 3'd0, 64'h410);
    drive(3, 1'b1, 1'b0, 1'b0, 3'd0, 64'h413);
    #1 chk("orph2_ready", bus.in_ready, 4'b1001);
    chk("orph2_pulse", bus.drop_pulse, 1);
    tick();
    idle_all();
    #1 chk("orph2_pulse_end", bus.drop_pulse, 0);
    chk("orph2_no_out", bus.out_valid, 0);
`ifdef AVL_STREAM_PKT_ARB_STATS_EN
    chk("orph2_drop_cnt", drop_cnt, 3);
    chk("pkt_cnt0", pkt_cnt[0*32 +: 32], 3);
    chk("pkt_cnt1", pkt_cnt[1*32 +: 32], 2);
    chk("pkt_cnt2", pkt_cnt[2*32 +: 32], 4);
    chk("pkt_cnt3", pkt_cnt[3*32 +: 32], 2);
`endif

    // ---- reset in the middle of a 5-beat packet from in3
    drive(3, 1'b1, 1'b1, 1'b0, 3'd0, 64'h500);
    tick();
    chk("rm_grant", bus.in_ready, 4'b1000);
    tick();
    chk("rm_b0_data", bus.out_data, 64'h500);
    drive(3, 1'b1, 1'b0, 1'b0, 3'd0, 64'h501);
    tick();
    chk("rm_b1_data", bus.out_data, 64'h501);
    drive(3, 1'b1, 1'b0, 1'b0, 3'd0, 64'h502);
    rst_n = 1'b0;
    #1 chk("rm_rst_ready", bus.in_ready, 0);
    tick();
    chk("rm_rst_valid", bus.out_valid, 0);
    chk("rm_rst_ready2", bus.in_ready, 0);
    rst_n = 1'b1;
    drive(3, 1'b1, 1'b1, 1'b1, 3'd1, 64'h600);
    #1 chk("rm_new_idle", bus.in_ready, 0);
    tick();
    chk("rm_new_grant", bus.in_ready, 4'b1000);
    chk("rm_new_nov", bus.out_valid, 0);
    tick();
    chk("rm_new_valid", bus.out_valid, 1);
    chk("rm_new_chan", bus.out_channel, 3);
    chk("rm_new_data", bus.out_data, 64'h600);
    chk("rm_new_flags", {bus.out_sop, bus.out_eop, bus.out_empty}, {1'b1, 1'b1, 3'd1});
    idle_all();
    tick();
    chk("rm_new_done", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/avl_stream_pkt_arb.md
Name: avl_stream_pkt_arb

Overview:
- Packet-level round-robin arbiter that merges NUM_IN Avalon-ST sources into one Avalon-ST sink.
- Grant is held from sop to eop, so packets never interleave.
- Output channel carries the source index.
- Sits in front of shared consumers (parser, DMA, flow-table ingress) that take one stream from several ports.

Parameters:
- NUM_IN, 4, number of input streams (2..16)
- WIDTH, 512, data bus width in bits (multiple of 8)
- EMPTY_W, $clog2(WIDTH/8), empty field width
- CHAN_W, max(1,$clog2(NUM_IN)), output channel width

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  NUM_IN*WIDTH  input i occupies slice [i*WIDTH +: WIDTH]
- in_valid  in  NUM_IN  per-input valid
- in_ready  out  NUM_IN  per-input ready
- in_sop  in  NUM_IN  start of packet
- in_eop  in  NUM_IN  end of packet
- in_empty  in  NUM_IN*EMPTY_W  empty bytes on eop beat
- in_almost_full  out  NUM_IN  backpressure hint to sources
- out_data  out  WIDTH  merged data
- out_valid  out  1  merged valid
- out_ready  in  1  sink ready
- out_sop  out  1  start of packet
- out_eop  out  1  end of packet
- out_empty  out  EMPTY_W  empty bytes on eop beat
- out_channel  out  CHAN_W  index of source input
- out_almost_full  in  1  sink almost full
- drop_pulse  out  1  one-cycle pulse per dropped orphan beat

Behaviour:
- Transfer rule: a beat moves when valid and ready are both high in the same cycle (ready latency 0).
- Reset (rst_n=0 at a clk edge): state=IDLE, rr_ptr=0, grant=0, out_valid=0, out_sop/eop/empty/channel/data=0, in_ready=0, drop_pulse=0. A packet in flight is abandoned with no eop; the sink must tolerate this.
- State IDLE:
  - Candidates = in_valid & in_sop.
  - If out_almost_full=1 or there are no candidates: stay IDLE.
  - Otherwise register grant = first candidate at or after rr_ptr (wrapping modulo NUM_IN), then go to BUSY.
  - Grant decision costs exactly 1 cycle; no beat is accepted in IDLE.
- State BUSY:
  - Stage enable en = ~out_valid | out_ready.
  - in_ready[g] = en; all other in_ready = 0, except orphan draining (below).
  - On accepting a beat from input g: the output register loads data/sop/eop/empty, out_channel=g, out_valid=1.
  - If en=1 and the granted input is not valid: out_valid<=0.
  - On an accepted beat with eop: rr_ptr <= g+1 (wrap to 0 past NUM_IN-1), then go to IDLE.
- Output register is one stage. Latency from input accept to out_valid is 1 cycle.
- Throughput: 1 beat/cycle within a packet; exactly 1 idle cycle between packets.
- Output signals hold stable while out_valid=1 and out_ready=0.
- Single-beat packet (sop and eop on the same beat) behaves as a normal packet: BUSY for one accept, then IDLE.
- Orphan beats:
  - In IDLE, any input with valid=1 and sop=0 gets in_ready=1 and its beat is dropped.
  - drop_pulse=1 for that cycle. Several orphans in the same cycle still produce a single pulse.
- in_almost_full[i] = out_almost_full, registered (1-cycle delay).
- out_almost_full is sampled only for the decision to start a packet. It never truncates a packet already in progress.
- The sop flag of beats inside a packet after the first is passed through unchecked.

Optional Feature:
- Macro: AVL_STREAM_PKT_ARB_STATS_EN.
- When defined, adds these outputs:
  - pkt_cnt (NUM_IN*32): per-input count of eop beats accepted.
  - drop_cnt (32): count of dropped orphan beats.
  - All counters are 0 at reset and wrap at 2^32-1 to 0.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package avl_arb_pkg holds:
  - typedef enum {IDLE, BUSY} arb_state_t
  - function rr_pick(req, ptr) returning {found, idx}
  - localparam STAT_W=32
- One natural sub-module: avl_rr_sel (combinational round-robin priority selector), reused by other arbiters.

Test Plan:
- Single source: in0 sends 3-beat packet (empty=5 on eop), out_ready=1 → out shows 3 beats, channel=0, sop on beat 1, eop+empty=5 on beat 3, first out_valid 2 cycles after in0 valid (1 grant + 1 register).
- Fairness: all 4 inputs hold 1-beat packets continuously → out_channel sequence 0,1,2,3,0,1…; each packet followed by 1 idle cycle.
- Backpressure: out_ready toggles 1,0,0,1 mid-packet → no beat lost or duplicated; out_data holds while stalled; all 8 beats arrive in order.
- Almost-full: out_almost_full=1 during IDLE with in2 valid+sop → no grant for as long as it is high. Asserting it mid-packet does not stop the current packet.
- Orphan: in1 valid with sop=0 while IDLE → in_ready[1]=1, drop_pulse=1 for one cycle, nothing on out. With AVL_STREAM_PKT_ARB_STATS_EN, drop_cnt=1.
- Reset mid-packet: rst_n=0 after beat 2 of 5 → next cycle out_valid=0, in_ready=0. After release, a new packet from in3 is granted normally.
